// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: frame-based reload that shortens as the formation
// thins, randomized round-robin column pick, and a valid/ready launch
// handshake toward a free enemy-bullet slot.
module enemy_fire_scheduler #(
    parameter int          NUM_SHOTS     = 2,
    parameter int          COOLDOWN_BASE = 60,
    parameter int          COOLDOWN_STEP = 2,
    parameter int          COOLDOWN_MIN  = 8,
    parameter int          COL_PITCH     = 73,
    parameter int          ROW_PITCH     = 50,
    parameter int          SHOT_X_OFF    = 16,
    parameter int          ENEMY_H       = 32,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         SLOT_W        = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 is_playing,
    input  logic [20:0]          alive_mask,
    input  logic [9:0]           origin_x,
    input  logic [9:0]           origin_y,
    input  logic [NUM_SHOTS-1:0] slot_busy,
    input  logic                 fire_ready,
    output logic                 fire_valid,
    output logic [9:0]           fire_x,
    output logic [9:0]           fire_y,
    output logic [SLOT_W-1:0]    fire_slot,
    output logic [7:0]           shots_fired
);

    typedef enum logic [1:0] {IDLE, COOLDOWN, SELECT, ISSUE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cooldown_q, cooldown_d;
    logic [2:0]         col_ptr_q, col_ptr_d;
    logic [2:0]         scan_cnt_q, scan_cnt_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [15:0]        lfsr_q;
    logic               fire_valid_d;
    logic [9:0]         fire_x_d, fire_y_d;
    logic [SLOT_W-1:0]  fire_slot_d;
    logic [7:0]         shots_fired_d;

    logic [4:0]         alive_cnt;
    logic [4:0]         dead_cnt;
    logic signed [7:0]  reload_raw;
    logic [7:0]         reload;
    logic               any_free;
    logic [SLOT_W-1:0]  free_idx;
    logic [6:0]         row0, row1, row2;
    logic               col_alive;
    logic [1:0]         row_sel;
    logic [10:0]        shot_x, shot_y;
    logic               col_valid;
    logic               abort;

    assign row0 = alive_mask[6:0];
    assign row1 = alive_mask[13:7];
    assign row2 = alive_mask[20:14];
    assign abort = !is_playing || (alive_mask == 21'd0);

    // Free-running LFSR supplying the random scan start column.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Reload value: fewer survivors means faster fire, floored at the minimum.
    always_comb begin
        alive_cnt = 5'd0;
        for (int i = 0; i < 21; i++) alive_cnt = alive_cnt + {4'd0, alive_mask[i]};
        dead_cnt   = 5'd21 - alive_cnt;
        // Signed 8-bit so a large dead count goes negative instead of wrapping high.
        reload_raw = 8'(COOLDOWN_BASE) - 8'(int'(dead_cnt) * COOLDOWN_STEP);
        reload     = (reload_raw < $signed(8'(COOLDOWN_MIN))) ? 8'(COOLDOWN_MIN) : reload_raw;
    end

    // Lowest-index free bullet slot.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                any_free = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    // Candidate shot for the column under the scan pointer; bottom row wins.
    always_comb begin
        col_alive = 1'b1;
        row_sel   = 2'd0;
        if (row2[col_ptr_q])      row_sel = 2'd2;
        else if (row1[col_ptr_q]) row_sel = 2'd1;
        else if (row0[col_ptr_q]) row_sel = 2'd0;
        else                      col_alive = 1'b0;
        shot_x    = {1'b0, origin_x} + 11'(col_ptr_q) * 11'(COL_PITCH) + 11'(SHOT_X_OFF);
        shot_y    = {1'b0, origin_y} + 11'(row_sel) * 11'(ROW_PITCH) + 11'(ENEMY_H);
        col_valid = col_alive && (shot_x <= 11'd639) && (shot_y <= 11'd479);
    end

    // Next-state and output logic for the fire sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d       = state_q;
        cooldown_d    = cooldown_q;
        col_ptr_d     = col_ptr_q;
        scan_cnt_d    = scan_cnt_q;
        slot_d        = slot_q;
        fire_valid_d  = fire_valid;
        fire_x_d      = fire_x;
        fire_y_d      = fire_y;
        fire_slot_d   = fire_slot;
        shots_fired_d = shots_fired;

        if (state_q != IDLE && abort) begin
            // Game stopped or formation wiped: drop any pending launch uncounted.
            state_d      = IDLE;
            fire_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_playing && alive_mask != 21'd0) begin
                        cooldown_d = reload;
                        state_d    = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (frame_tick && cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
                    if (cooldown_q == 8'd0 && any_free) begin
                        slot_d     = free_idx;
                        col_ptr_d  = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
                        scan_cnt_d = 3'd0;
                        state_d    = SELECT;
                    end
                end
                SELECT: begin
                    if (col_valid) begin
                        fire_x_d     = shot_x[9:0];
                        fire_y_d     = shot_y[9:0];
                        fire_slot_d  = slot_q;
                        fire_valid_d = 1'b1;
                        state_d      = ISSUE;
                    end else begin
                        col_ptr_d = (col_ptr_q == 3'd6) ? 3'd0 : col_ptr_q + 3'd1;
                        if (scan_cnt_q == 3'd6) begin
                            cooldown_d = reload;
                            state_d    = COOLDOWN;
                        end else begin
                            scan_cnt_d = scan_cnt_q + 3'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (fire_ready) begin
                        fire_valid_d  = 1'b0;
                        shots_fired_d = shots_fired + 8'd1;
                        cooldown_d    = reload;
                        state_d       = COOLDOWN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cooldown_q  <= 8'd0;
            col_ptr_q   <= 3'd0;
            scan_cnt_q  <= 3'd0;
            slot_q      <= '0;
            fire_valid  <= 1'b0;
            fire_x      <= 10'd0;
            fire_y      <= 10'd0;
            fire_slot   <= '0;
            shots_fired <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together at the edge.
            state_q     <= state_d;
            cooldown_q  <= cooldown_d;
            col_ptr_q   <= col_ptr_d;
            scan_cnt_q  <= scan_cnt_d;
            slot_q      <= slot_d;
            fire_valid  <= fire_valid_d;
            fire_x      <= fire_x_d;
            fire_y      <= fire_y_d;
            fire_slot   <= fire_slot_d;
            shots_fired <= shots_fired_d;
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Self-checking bench for enemy_fire_scheduler: directed scenarios plus
// randomized rounds, all compared against a behavioural reference model.
module tb_enemy_fire_scheduler;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic        is_playing;
    logic [20:0] alive_mask;
    logic [9:0]  origin_x;
    logic [9:0]  origin_y;
    logic [1:0]  slot_busy;
    logic        fire_ready;
    logic        fire_valid;
    logic [9:0]  fire_x;
    logic [9:0]  fire_y;
    logic [0:0]  fire_slot;
    logic [7:0]  shots_fired;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tick_div = 3;

    // Reference model state (phase: 0 idle, 1 reloading, 2 scanning, 3 offering).
    int          m_phase, m_cool, m_shots, m_x, m_y, m_slot, m_scan_left;
    int          m_hit_x, m_hit_y;
    bit          m_valid, m_hit;
    logic [15:0] m_lfsr;

    enemy_fire_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .is_playing(is_playing),
        .alive_mask(alive_mask), .origin_x(origin_x), .origin_y(origin_y),
        .slot_busy(slot_busy), .fire_ready(fire_ready), .fire_valid(fire_valid),
        .fire_x(fire_x), .fire_y(fire_y), .fire_slot(fire_slot), .shots_fired(shots_fired)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int reload_of(input logic [20:0] m);
        int r;
        r = 60 - (21 - $countones(m)) * 2;
        return (r < 8) ? 8 : r;
    endfunction

    // Shot position for column c from the current formation inputs; 1 if on screen.
    function automatic bit col_shot(input int c, output int x, output int y);
        int r;
        x = 0;
        y = 0;
        if (alive_mask[14 + c])     r = 2;
        else if (alive_mask[7 + c]) r = 1;
        else if (alive_mask[c])     r = 0;
        else return 1'b0;
        x = int'(origin_x) + c * 73 + 16;
        y = int'(origin_y) + r * 50 + 32;
        return (x <= 639) && (y <= 479);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cool = 0; m_shots = 0; m_valid = 0;
        m_x = 0; m_y = 0; m_slot = 0; m_scan_left = 0; m_hit = 0;
        m_lfsr = 16'hACE1;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        bit ok;
        int start, c, x, y;
        ok = is_playing && (alive_mask != 0);
        if (m_phase != 0 && !ok) begin
            m_phase = 0;
            m_valid = 0;
        end else begin
            case (m_phase)
                0: if (ok) begin m_cool = reload_of(alive_mask); m_phase = 1; end
                1: begin
                    if (m_cool == 0 && slot_busy != 2'b11) begin
                        m_slot = slot_busy[0] ? 1 : 0;
                        start  = int'(m_lfsr[2:0]);
                        if (start == 7) start = 0;
                        // Plan the whole scan up front: the first on-screen column in rotation wins.
                        m_hit = 0;
                        m_scan_left = 6;
                        for (int k = 0; k < 7; k++) begin
                            c = (start + k) % 7;
                            if (!m_hit && col_shot(c, x, y)) begin
                                m_hit = 1; m_scan_left = k; m_hit_x = x; m_hit_y = y;
                            end
                        end
                        m_phase = 2;
                    end else if (frame_tick && m_cool > 0) begin
                        m_cool--;
                    end
                end
                2: begin
                    if (m_scan_left > 0) m_scan_left--;
                    else if (m_hit) begin
                        m_valid = 1; m_x = m_hit_x; m_y = m_hit_y; m_phase = 3;
                    end else begin
                        m_cool = reload_of(alive_mask); m_phase = 1;
                    end
                end
                default: if (fire_ready) begin
                    m_valid = 0; m_shots = (m_shots + 1) % 256;
                    m_cool = reload_of(alive_mask); m_phase = 1;
                end
            endcase
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    // One clock: drive frame_tick, advance the model, sample 1 time unit after the edge.
    task automatic step();
        frame_tick = (cyc % tick_div == 0);
        model_step();
        @(posedge Clk);
        #1;
        cyc++;
        check("fire_valid", fire_valid, m_valid);
        check("shots_fired", shots_fired, m_shots);
        if (m_valid) begin
            check("fire_x", fire_x, m_x);
            check("fire_y", fire_y, m_y);
            check("fire_slot", fire_slot, m_slot);
        end
    endtask

    task automatic new_round(input logic [20:0] m, input int ox, input int oy);
        is_playing = 1'b0;
        step();
        alive_mask = m;
        origin_x   = 10'(ox);
        origin_y   = 10'(oy);
        is_playing = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && fire_valid !== 1'b1; i++) step();
        check({tag, "_seen"}, fire_valid, 1'b1);
    endtask

    initial begin
        int saved_x, saved_y, saved_slot, saved_shots, gap, highs;
        logic [20:0] rm;

        Reset = 1'b0; frame_tick = 1'b0; is_playing = 1'b0; alive_mask = '0;
        origin_x = '0; origin_y = '0; slot_busy = '0; fire_ready = 1'b0;
        model_reset();
        #1;
        check("rst_valid", fire_valid, 1'b0);
        check("rst_x", fire_x, 0);
        check("rst_shots", shots_fired, 0);
        #20 Reset = 1'b1;

        // Async reset while a launch is pending.
        fire_ready = 1'b0;
        new_round(21'h1FFFFF, 0, 0);
        wait_valid("pre_reset", 400);
        Reset = 1'b0;
        model_reset();
        #2;
        check("async_valid", fire_valid, 1'b0);
        check("async_x", fire_x, 0);
        check("async_y", fire_y, 0);
        check("async_slot", fire_slot, 0);
        check("async_shots", shots_fired, 0);
        is_playing = 1'b0;
        #1 Reset = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Single enemy at row 2, col 2.
        fire_ready = 1'b1;
        new_round(21'h1 << 16, 100, 20);
        wait_valid("single", 300);
        check("single_x", fire_x, 262);
        check("single_y", fire_y, 152);
        check("single_slot", fire_slot, 0);
        step();
        check("single_count", shots_fired, 1);

        // Column 3 alive in rows 0 and 1: row 1 wins.
        new_round((21'h1 << 3) | (21'h1 << 10), 0, 0);
        wait_valid("rowpri", 300);
        check("rowpri_x", fire_x, 235);
        check("rowpri_y", fire_y, 82);

        // Full formation: one frame per cycle, reload of 60 frames.
        tick_div = 1;
        new_round(21'h1FFFFF, 0, 0);
        wait_valid("full_first", 300);
        step();
        gap = 0;
        while (fire_valid !== 1'b1 && gap < 200) begin step(); gap++; end
        check("reload60_gap", gap, 62);

        // Slot selection and all-busy hold.
        slot_busy = 2'b01;
        new_round(21'h1FFFFF, 0, 0);
        wait_valid("slot1", 200);
        check("slot1_idx", fire_slot, 1);
        slot_busy = 2'b11;
        new_round(21'h1FFFFF, 0, 0);
        highs = 0;
        for (int i = 0; i < 120; i++) begin step(); if (fire_valid) highs++; end
        check("allbusy_none", highs, 0);
        slot_busy = 2'b10;
        wait_valid("slot0", 20);
        check("slot0_idx", fire_slot, 0);

        // Back-pressure holds the offer stable, then abort drops it uncounted.
        slot_busy = 2'b00;
        fire_ready = 1'b0;
        new_round(21'h1FFFFF, 40, 30);
        wait_valid("hold", 200);
        saved_x = fire_x; saved_y = fire_y; saved_slot = fire_slot; saved_shots = shots_fired;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", fire_valid, 1'b1);
            check("hold_x", fire_x, saved_x);
            check("hold_y", fire_y, saved_y);
            check("hold_slot", fire_slot, saved_slot);
        end
        fire_ready = 1'b1;
        is_playing = 1'b0;
        step();
        check("abort_valid", fire_valid, 1'b0);
        check("abort_shots", shots_fired, saved_shots);

        // Only col 6 alive but off-screen: every scan fails.
        new_round(21'h1 << 6, 600, 0);
        highs = 0;
        for (int i = 0; i < 150; i++) begin step(); if (fire_valid) highs++; end
        check("offscreen_none", highs, 0);

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            rm = 21'($urandom) & 21'($urandom);
            if (rm == 0) rm = 21'h1 << $urandom_range(0, 20);
            new_round(rm, $urandom_range(0, 700), $urandom_range(0, 450));
            for (int i = 0; i < 150; i++) begin
                fire_ready = ($urandom_range(0, 3) != 0);
                slot_busy  = 2'($urandom_range(0, 3));
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
Decides when and from where the enemy formation fires. It tracks the 3x7 alive mask and the formation origin, and runs a frame-based cooldown that shortens as enemies die. It arbitrates among alive columns using a randomized round-robin start, and hands a launch request to a free enemy-bullet slot. It sits between the enemy formation logic (alive mask, origin) and the enemy bullet instances.

Parameters:
NUM_SHOTS, 2, number of enemy bullet slots arbitrated
COOLDOWN_BASE, 60, frames between shots with all 21 enemies alive
COOLDOWN_STEP, 2, frames removed from the reload per dead enemy
COOLDOWN_MIN, 8, floor of the reload value
COL_PITCH, 73, horizontal spacing of columns in pixels
ROW_PITCH, 50, vertical spacing of rows in pixels
SHOT_X_OFF, 16, horizontal offset of the muzzle inside an enemy sprite
ENEMY_H, 32, enemy sprite height; the shot spawns directly below the sprite
LFSR_SEED, 16'hACE1, reset value of the internal LFSR

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-Clk pulse per video frame, already in the Clk domain
is_playing  in  1  game active
alive_mask  in  21  bits 0-6 easy row (row 0), bits 7-13 medium row (row 1), bits 14-20 hard row (row 2); bit index = row*7+col
origin_x  in  10  formation left edge
origin_y  in  10  formation top edge
slot_busy  in  NUM_SHOTS  bullet slot i is in flight
fire_ready  in  1  selected bullet slot accepts the launch
fire_valid  out  1  launch request
fire_x  out  10  spawn X
fire_y  out  10  spawn Y
fire_slot  out  clog2(NUM_SHOTS)  target slot
shots_fired  out  8  wrapping count of accepted launches

Behaviour:
- Reset low (any time, asynchronous): state IDLE, fire_valid=0, fire_x=0, fire_y=0, fire_slot=0, shots_fired=0, cooldown=0, col_ptr=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci with taps 16,14,13,11. It advances every Clk cycle in every state.
- alive_cnt = popcount(alive_mask), 5 bits.
- reload = max(COOLDOWN_MIN, COOLDOWN_BASE - (21-alive_cnt)*COOLDOWN_STEP). Compute in signed 8 bits so the subtraction cannot underflow.
- States:
  IDLE: if is_playing && alive_mask!=0, load cooldown=reload and go to COOLDOWN.
  COOLDOWN: on frame_tick, decrement cooldown if it is nonzero (it saturates at 0). When cooldown==0 and any slot_busy bit is 0, latch slot = lowest free index, set col_ptr = LFSR[2:0] (value 7 maps to 0), set scan_cnt=0, and go to SELECT. When cooldown==0 and all slots are busy, hold.
  SELECT: each cycle examine one column (col_ptr).
    - Column valid = any alive row in that column, and the computed x<=639 and y<=479.
    - Bottom-most alive row r wins: row 2 has priority over row 1, row 1 over row 0.
    - x = origin_x + col*COL_PITCH + SHOT_X_OFF; y = origin_y + r*ROW_PITCH + ENEMY_H. Both are computed in 11 bits.
    - If the column is valid, register fire_x, fire_y (low 10 bits) and fire_slot, and go to ISSUE.
    - Otherwise col_ptr = (col_ptr+1) mod 7 and scan_cnt++. After 7 failed columns, load cooldown=reload and go to COOLDOWN (no shot this round).
  ISSUE: fire_valid=1. fire_x, fire_y and fire_slot are held stable until fire_ready. On fire_valid && fire_ready: next cycle fire_valid=0, shots_fired++ (wraps at 255), load cooldown=reload, go to COOLDOWN.
- Latency: fire_valid rises k+1 cycles after SELECT entry, where k = number of invalid columns skipped (k=0..6).
- In any non-IDLE state, if is_playing=0 or alive_mask==0: go to IDLE next cycle and drop fire_valid without handshake. This takes priority over all other transitions, including a simultaneous fire_ready; that launch is not counted.
- The slot is not rechecked during ISSUE. The bullet owner must keep fire_ready low while that slot is busy.
- frame_tick is ignored outside COOLDOWN.
- alive_mask and origin are sampled each SELECT cycle. A change mid-scan affects only columns not yet examined.

Test Plan:
1. Assert Reset mid-ISSUE -> all outputs 0 immediately (asynchronous). After release, state is IDLE and no fire_valid until is_playing=1.
2. alive_mask=bit16 only (row 2, col 2), origin=(100,20), slots free, fire_ready=1 -> reload=max(8,60-40)=20. After 20 frame_ticks plus a scan of at most 7 cycles: fire_x=262, fire_y=152, fire_slot=0, shots_fired=1.
3. alive_mask=bits 3 and 10, origin=(0,0) -> fire_x=235, fire_y=82 (row 1 wins over row 0). Full mask alive -> reload=60 frames between launches.
4. slot_busy=2'b01 -> fire_slot=1. slot_busy=2'b11 -> no fire_valid while held; clear bit 0 -> SELECT follows, fire_slot=0.
5. fire_ready low for 5 cycles in ISSUE -> fire_valid, fire_x, fire_y and fire_slot stay constant. Then drop is_playing -> fire_valid=0 next cycle, state IDLE, shots_fired unchanged.
6. Only col 6 alive, origin_x=600 (x=1054>639) -> no fire_valid. Return to COOLDOWN after 7 scan cycles with cooldown=reload.
